addsub_serial_unit: RTL and testbench
=====================================

Name: addsub_serial_unit

Overview:
Parametrised multi-cycle adder/subtractor, the sequential successor to the ALU's 9-bit conditional-invert word gate. It latches two WIDTH-bit operands and processes them CHUNK bits per clock. Subtraction uses XOR inversion of B plus carry-in = 1. It uses a start/ready/done handshake and registered flags, and sits between the ALU operand registers and the result/flag register.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CHUNK, 4, bits processed per clock; WIDTH must be an integer multiple of CHUNK (elaboration error otherwise)
(derived) STEPS = WIDTH/CHUNK, processing cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
sub  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
ready  output  1  high only in IDLE
busy  output  1  high in RUN
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  sum/difference, registered
carry_out  output  1  carry from MSB; for sub, 1 = no borrow (A >= B unsigned)
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free. ready = (state==IDLE), busy = (state==RUN), done = (state==DONE).
- Reset (rst_n=0, asynchronous, immediate):
  - state=IDLE; step counter=0; internal operand/carry registers=0.
  - result=0, carry_out=0, overflow=0, zero=0.
  - ready=1, busy=0, done=0.
  - Reset mid-RUN or in DONE aborts the operation with no done pulse.
- IDLE, start=1 at edge E0:
  - Latch a into opA.
  - Latch b XOR {WIDTH{sub}} into opB.
  - Set carry = sub, counter = 0, and record msbA = a[WIDTH-1], msbB = opB MSB.
  - Go to RUN.
- IDLE, start=0: remain in IDLE. Outputs hold.
- RUN, each edge:
  - CHUNK-bit add of opA[CHUNK-1:0] + opB[CHUNK-1:0] + carry.
  - Shift the sum chunk into the result shift register from the MSB side; shift opA and opB right by CHUNK.
  - carry = chunk carry-out; counter++.
  - On the edge where counter reaches STEPS-1 (edge E_STEPS):
    - Update result.
    - carry_out = final carry.
    - overflow = (msbA == msbB) && (result MSB != msbA).
    - zero = (result == 0).
    - Go to DONE.
- DONE: lasts exactly one cycle, then unconditional return to IDLE. done=1 during this cycle.
- Latency: done is high in the cycle after edge E_STEPS, i.e. STEPS cycles after the accepting edge. Throughput is one operation per STEPS+2 cycles.
- result and flags change only at the RUN->DONE edge or on reset. They hold their values through IDLE and the next RUN until that operation completes.
- start while RUN or DONE is ignored, with no queuing. Changes to a, b or sub after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. carry_out is the true unsigned carry of A + (B XOR sub) + sub.
- CHUNK == WIDTH is legal: single RUN cycle, latency 1.

Test Plan:
1. WIDTH=8, CHUNK=4: start with a=0x2D, b=0x13, sub=0 -> done exactly 2 cycles after the accepting edge; result=0x40, carry_out=0, overflow=0, zero=0; ready back to 1 one cycle after done.
2. Signed and unsigned corner cases:
   - a=0x7F + b=0x01 -> result=0x80, overflow=1, carry_out=0.
   - a=0xFF + b=0x01 -> result=0x00, carry_out=1, zero=1, overflow=0.
3. Subtraction:
   - a=0x05 - b=0x05 -> result=0x00, carry_out=1, zero=1.
   - a=0x03 - b=0x05 -> result=0xFE, carry_out=0, overflow=0.
   - a=0x80 - b=0x01 -> result=0x7F, overflow=1.
4. Handshake and reset:
   - Assert start with new operands while busy=1 -> ignored; first result unchanged; no extra done pulse.
   - Change a/b mid-RUN -> result unaffected.
   - Drop rst_n mid-RUN -> immediately result=0, all flags=0, ready=1, done never pulses.
5. Parametrisation WIDTH=9, CHUNK=1: 0x1FF + 0x001 -> done 9 cycles after accept, result=0x000, carry_out=1, zero=1. Same config with 0x0AA - 0x055 -> result=0x055, carry_out=1.
6. Randomised back-to-back ops (start held high) across WIDTH/CHUNK in {8/2, 8/8, 16/4} vs reference model -> results and flags match; the next accept occurs exactly one cycle after each done.

Source files
------------

// File: rtl/addsub_serial_unit_if.sv
// addsub_serial_unit_if: operand/request and result/flag bundle for the serial adder/subtractor.
interface addsub_serial_unit_if #(parameter int WIDTH = 8);
  logic start, sub, ready, busy, done, carry_out, overflow, zero;
  logic [WIDTH-1:0] a, b, result;
  modport master (output start, sub, a, b, input ready, busy, done, result, carry_out, overflow, zero);
  modport slave (input start, sub, a, b, output ready, busy, done, result, carry_out, overflow, zero);
endinterface

// File: rtl/addsub_serial_unit.sv
// addsub_serial_unit: multi-cycle add/sub processing CHUNK bits per clock with start/ready/done handshake.
module addsub_serial_unit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst_n,
  addsub_serial_unit_if.slave bus
);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad
    $error("addsub_serial_unit: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sh_q, sh_d, result_q, result_d, shifted;
  logic cy_q, cy_d, msba_q, msba_d, msbb_q, msbb_d, co_q, co_d, ov_q, ov_d, z_q, z_d;
  logic [CHUNK:0] csum;
  logic last;
  assign csum = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
  assign last = cnt_q == CW'(STEPS - 1);
  // sum chunks enter at the MSB so the final chunk lands in the top slice
  assign shifted = (sh_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = cnt_q;
    opa_d = opa_q;
    opb_d = opb_q;
    sh_d = sh_q;
    cy_d = cy_q;
    msba_d = msba_q;
    msbb_d = msbb_q;
    result_d = result_q;
    co_d = co_q;
    ov_d = ov_q;
    z_d = z_q;
    if (state_q == IDLE && bus.start) begin
      opa_d = bus.a;
      opb_d = bus.b ^ {WIDTH{bus.sub}};
      cy_d = bus.sub;
      cnt_d = '0;
      msba_d = bus.a[WIDTH-1];
      msbb_d = bus.b[WIDTH-1] ^ bus.sub;
    end
    if (state_q == RUN) begin
      opa_d = opa_q >> CHUNK;
      opb_d = opb_q >> CHUNK;
      cy_d = csum[CHUNK];
      cnt_d = cnt_q + CW'(1);
      sh_d = shifted;
      if (last) begin
        result_d = shifted;
        co_d = csum[CHUNK];
        ov_d = (msba_q == msbb_q) && (shifted[WIDTH-1] != msba_q);
        z_d = shifted == '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      sh_q <= '0;
      cy_q <= 1'b0;
      msba_q <= 1'b0;
      msbb_q <= 1'b0;
      result_q <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      sh_q <= sh_d;
      cy_q <= cy_d;
      msba_q <= msba_d;
      msbb_q <= msbb_d;
      result_q <= result_d;
      co_q <= co_d;
      ov_q <= ov_d;
      z_q <= z_d;
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.result = result_q;
  assign bus.carry_out = co_q;
  assign bus.overflow = ov_q;
  assign bus.zero = z_q;
endmodule

// File: tb/tb_addsub_serial_unit.sv
// tb_addsub_serial_unit: directed and randomised checks of several WIDTH/CHUNK configurations.
module tb_addsub_serial_unit;
  localparam int N = 5;
  function automatic int wof(int k);
    return k == 1 ? 9 : k == 4 ? 16 : 8;
  endfunction
  function automatic int cof(int k);
    return k == 0 ? 4 : k == 1 ? 1 : k == 2 ? 2 : k == 3 ? 8 : 4;
  endfunction
  typedef struct packed {logic [15:0] r; logic c, v, z;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] start_s = '0;
  logic sub_s = 1'b0;
  logic [15:0] a_s = '0, b_s = '0;
  logic [15:0] res [N];
  logic [N-1:0] co, ov, zr, rdy, bsy, dn;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = wof(g);
    localparam int C = cof(g);
    addsub_serial_unit_if #(.WIDTH(W)) u_if ();
    assign u_if.start = start_s[g];
    assign u_if.sub = sub_s;
    assign u_if.a = a_s[W-1:0];
    assign u_if.b = b_s[W-1:0];
    assign res[g] = 16'(u_if.result);
    assign co[g] = u_if.carry_out;
    assign ov[g] = u_if.overflow;
    assign zr[g] = u_if.zero;
    assign rdy[g] = u_if.ready;
    assign bsy[g] = u_if.busy;
    assign dn[g] = u_if.done;
    addsub_serial_unit #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  end
  // signed/unsigned reference from plain integer arithmetic
  function automatic exp_t model(int w, bit s, logic [15:0] a, logic [15:0] b);
    exp_t e;
    longint m, ua, ub, sum, sa, sb, t, h;
    m = (longint'(1) << w) - 1;
    h = (m + 1) / 2;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sum = s ? ua + (~ub & m) + 1 : ua + ub;
    sa = ua >= h ? ua - (m + 1) : ua;
    sb = ub >= h ? ub - (m + 1) : ub;
    t = s ? sa - sb : sa + sb;
    e.r = 16'(sum & m);
    e.c = ((sum >> w) & 1) != 0;
    e.v = t >= h || t < -h;
    e.z = (sum & m) == 0;
    return e;
  endfunction
  task automatic wait_done(input int k, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!dn[k] && n < 40);
  endtask
  task automatic do_op(input int k, input bit s, input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    sub_s = s;
    a_s = a;
    b_s = b;
    start_s[k] = 1'b1;
    @(posedge clk);
    #1 start_s[k] = 1'b0;
    wait_done(k, lat);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if ({res[k], co[k], ov[k], zr[k], rdy[k], bsy[k], dn[k]} !== {16'h0, 3'b000, 3'b100}) begin
        n_fail++;
        $display("FAIL reset k=%0d got r=%h c%b v%b z%b rdy%b bsy%b dn%b want all 0, ready=1", k, res[k], co[k], ov[k], zr[k], rdy[k], bsy[k], dn[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    int lat;
    do_op(0, 1'b0, 16'h2D, 16'h13, lat);
    n_chk++;
    if (lat !== 2) begin n_fail++; $display("FAIL basic_latency got %0d want 2", lat); end
    n_chk++;
    if ({res[0], co[0], ov[0], zr[0]} !== {16'h40, 3'b000}) begin
      n_fail++;
      $display("FAIL basic_result got r=%h c%b v%b z%b want r=40 c0 v0 z0", res[0], co[0], ov[0], zr[0]);
    end
    @(negedge clk);
    n_chk++;
    if ({rdy[0], dn[0]} !== 2'b10) begin n_fail++; $display("FAIL basic_ready_after got rdy%b dn%b want rdy1 dn0", rdy[0], dn[0]); end
  endtask
  task automatic test_corners();
    logic [15:0] ta [5] = '{16'h7F, 16'hFF, 16'h05, 16'h03, 16'h80};
    logic [15:0] tb [5] = '{16'h01, 16'h01, 16'h05, 16'h05, 16'h01};
    bit ts [5] = '{0, 0, 1, 1, 1};
    exp_t te [5] = '{'{16'h80, 0, 1, 0}, '{16'h00, 1, 0, 1}, '{16'h00, 1, 0, 1}, '{16'hFE, 0, 0, 0}, '{16'h7F, 1, 1, 0}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(0, ts[i], ta[i], tb[i], lat);
      n_chk++;
      if (lat !== 2) begin n_fail++; $display("FAIL corner_latency i=%0d got %0d want 2", i, lat); end
      n_chk++;
      if ({res[0], co[0], ov[0], zr[0]} !== te[i]) begin
        n_fail++;
        $display("FAIL corner i=%0d got r=%h c%b v%b z%b want r=%h c%b v%b z%b", i, res[0], co[0], ov[0], zr[0], te[i].r, te[i].c, te[i].v, te[i].z);
      end
    end
  endtask
  task automatic test_busy_start();
    int lat, pulses;
    @(negedge clk);
    sub_s = 1'b0;
    a_s = 16'h10;
    b_s = 16'h20;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    sub_s = 1'b1;
    a_s = 16'h77;
    b_s = 16'h11;
    @(negedge clk);
    n_chk++;
    if ({bsy[0], rdy[0]} !== 2'b10) begin n_fail++; $display("FAIL busy_flag got bsy%b rdy%b want bsy1 rdy0", bsy[0], rdy[0]); end
    wait_done(0, lat);
    start_s[0] = 1'b0;
    n_chk++;
    if (lat !== 2) begin n_fail++; $display("FAIL busy_latency got %0d want 2", lat); end
    n_chk++;
    if ({res[0], co[0], ov[0], zr[0]} !== {16'h30, 3'b000}) begin
      n_fail++;
      $display("FAIL busy_result got r=%h c%b v%b z%b want r=30 c0 v0 z0", res[0], co[0], ov[0], zr[0]);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(dn[0]);
    end
    n_chk++;
    if (pulses !== 0) begin n_fail++; $display("FAIL busy_extra_done got %0d pulses want 0", pulses); end
  endtask
  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    sub_s = 1'b0;
    a_s = 16'h01;
    b_s = 16'h02;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({res[0], co[0], ov[0], zr[0], rdy[0], bsy[0], dn[0]} !== {16'h0, 3'b000, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_mid got r=%h c%b v%b z%b rdy%b bsy%b dn%b want all 0, ready=1", res[0], co[0], ov[0], zr[0], rdy[0], bsy[0], dn[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(dn[0]);
    end
    n_chk++;
    if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid_done got %0d pulses want 0", pulses); end
  endtask
  task automatic test_param();
    int lat;
    do_op(1, 1'b0, 16'h1FF, 16'h001, lat);
    n_chk++;
    if (lat !== 9) begin n_fail++; $display("FAIL param_latency got %0d want 9", lat); end
    n_chk++;
    if ({res[1], co[1], ov[1], zr[1]} !== {16'h000, 3'b101}) begin
      n_fail++;
      $display("FAIL param_add got r=%h c%b v%b z%b want r=000 c1 v0 z1", res[1], co[1], ov[1], zr[1]);
    end
    do_op(1, 1'b1, 16'h0AA, 16'h055, lat);
    n_chk++;
    if ({res[1], co[1], ov[1], zr[1]} !== {16'h055, 3'b100}) begin
      n_fail++;
      $display("FAIL param_sub got r=%h c%b v%b z%b want r=055 c1 v0 z0", res[1], co[1], ov[1], zr[1]);
    end
  endtask
  task automatic test_back_to_back(input int k, input int nops);
    exp_t e;
    int lat;
    @(negedge clk);
    sub_s = 1'($urandom);
    a_s = 16'($urandom);
    b_s = 16'($urandom);
    start_s[k] = 1'b1;
    for (int i = 0; i < nops; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = model(wof(k), sub_s, a_s, b_s);
      sub_s = 1'($urandom);
      a_s = 16'($urandom);
      b_s = 16'($urandom);
      wait_done(k, lat);
      n_chk++;
      if (lat !== wof(k) / cof(k)) begin n_fail++; $display("FAIL b2b_latency k=%0d op=%0d got %0d want %0d", k, i, lat, wof(k) / cof(k)); end
      n_chk++;
      if ({res[k], co[k], ov[k], zr[k]} !== e) begin
        n_fail++;
        $display("FAIL b2b k=%0d op=%0d got r=%h c%b v%b z%b want r=%h c%b v%b z%b", k, i, res[k], co[k], ov[k], zr[k], e.r, e.c, e.v, e.z);
      end
      if (i == nops - 1) start_s[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (rdy[k] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready k=%0d op=%0d got %b want 1", k, i, rdy[k]); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_busy_start();
    test_reset_mid();
    test_param();
    test_back_to_back(2, 12);
    test_back_to_back(3, 12);
    test_back_to_back(4, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
